ac_reg: RTL and testbench



---
 rtl/ac_reg_if.sv | 41 ++++
 rtl/ac_reg.sv | 43 ++++
 tb/tb_ac_reg.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ac_reg_if.sv
// ----------------------------------------------------------------------------
// ac_reg_if
// Bus bundle between the control unit / datapath (master) and the
// accumulator register (slave).
//
// Signals:
//   write  master->slave  load strobe, sampled on the rising clock edge
//   read   master->slave  output enable for dout (combinational)
//   din    master->slave  WIDTH-bit word to be loaded
//   dout   slave->master  accumulator contents while read=1, else zero
//   zero   slave->master  accumulator == 0
//   neg    slave->master  accumulator MSB
// ----------------------------------------------------------------------------
interface ac_reg_if #(
    parameter int WIDTH = 18
);
    logic             write;
    logic             read;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             zero;
    logic             neg;

    modport master (
        output write,
        output read,
        output din,
        input  dout,
        input  zero,
        input  neg
    );

    modport slave (
        input  write,
        input  read,
        input  din,
        output dout,
        output zero,
        output neg
    );
endinterface

// File: rtl/ac_reg.sv
// ----------------------------------------------------------------------------
// ac_reg
// Accumulator (AC) register of the processor datapath. Loads din verbatim on
// a write strobe, drives its contents onto dout only while read is high, and
// reports zero/sign status for conditional branches.
//
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset; forces the register to RESET_VALUE
//   bus    ac_reg_if slave modport (write, read, din, dout, zero, neg)
// ----------------------------------------------------------------------------
module ac_reg #(
    parameter int               WIDTH       = 18,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    ac_reg_if.slave  bus
);

    logic [WIDTH-1:0] r_acc;
    logic             w_zero;
    logic             w_neg;

    // Reset wins over write; the new value is visible on dout from the edge
    // onward, so a same-cycle read sees the old contents before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= RESET_VALUE;
        end else if (bus.write) begin
            r_acc <= bus.din;
        end
    end

    // Status flags follow the register itself, not the gated output bus.
    assign w_zero = (r_acc == '0);
    assign w_neg  = r_acc[WIDTH-1];

    assign bus.dout = bus.read ? r_acc : '0;
    assign bus.zero = w_zero;
    assign bus.neg  = w_neg;

endmodule

// File: tb/tb_ac_reg.sv
// ----------------------------------------------------------------------------
// tb_ac_reg
// Directed-vector bench for the accumulator register. Inputs change on the
// falling edge (or mid-cycle for the asynchronous reset), outputs are sampled
// 1 time unit after the rising edge or between edges.
// ----------------------------------------------------------------------------
module tb_ac_reg;
    localparam int WIDTH = 18;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    ac_reg_if #(.WIDTH(WIDTH)) bus ();

    ac_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE ('0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%05h, expected 0x%05h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        @(negedge clk);
        bus.write = 1'b1;
        bus.din   = v;
        @(posedge clk);
        #1;
        bus.write = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.write = 1'b0;
        bus.read  = 1'b0;
        bus.din   = '0;

        // Power-on reset
        #2;
        chk("rst_dout_rd0", 32'(bus.dout), 32'h0);
        chk("rst_zero",     32'(bus.zero), 32'h1);
        chk("rst_neg",      32'(bus.neg),  32'h0);
        bus.read = 1'b1;
        #1;
        chk("rst_dout_rd1", 32'(bus.dout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-ones word, then asynchronous mid-cycle reset
        load(18'h3FFFF);
        chk("ones_dout", 32'(bus.dout), 32'h3FFFF);
        chk("ones_neg",  32'(bus.neg),  32'h1);
        chk("ones_zero", 32'(bus.zero), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dout", 32'(bus.dout), 32'h0);
        chk("async_rst_zero", 32'(bus.zero), 32'h1);
        chk("async_rst_neg",  32'(bus.neg),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load then read, read gating
        load(18'h0000B);
        chk("load_b_dout", 32'(bus.dout), 32'h0000B);
        chk("load_b_zero", 32'(bus.zero), 32'h0);
        bus.read = 1'b0;
        #1;
        chk("rd0_dout",    32'(bus.dout), 32'h0);
        chk("rd0_zero",    32'(bus.zero), 32'h0);
        bus.read = 1'b1;
        #1;
        chk("reread_dout", 32'(bus.dout), 32'h0000B);

        // Simultaneous read and write
        @(negedge clk);
        bus.write = 1'b1;
        bus.din   = 18'h0000F;
        #1;
        chk("rw_before_edge", 32'(bus.dout), 32'h0000B);
        @(posedge clk);
        #1;
        bus.write = 1'b0;
        chk("rw_after_edge",  32'(bus.dout), 32'h0000F);

        // Hold with din toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.din = (i % 2 == 0) ? 18'h15555 : 18'h2AAAA;
            @(posedge clk);
            #1;
            chk("hold_dout", 32'(bus.dout), 32'h0000F);
        end

        // Flags
        load(18'h20000);
        chk("msb_neg",  32'(bus.neg),  32'h1);
        chk("msb_zero", 32'(bus.zero), 32'h0);
        chk("msb_dout", 32'(bus.dout), 32'h20000);
        load(18'h00000);
        chk("z_zero", 32'(bus.zero), 32'h1);
        chk("z_neg",  32'(bus.neg),  32'h0);
        load(18'h3FFFF);
        chk("ones2_dout", 32'(bus.dout), 32'h3FFFF);
        chk("ones2_neg",  32'(bus.neg),  32'h1);

        // Reset priority over write
        @(negedge clk);
        rst_n     = 1'b0;
        bus.write = 1'b1;
        bus.din   = 18'h12345;
        @(posedge clk);
        #1;
        chk("rstpri_dout", 32'(bus.dout), 32'h0);
        chk("rstpri_zero", 32'(bus.zero), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.write = 1'b0;
        chk("post_rst_load", 32'(bus.dout), 32'h12345);
        chk("post_rst_zero", 32'(bus.zero), 32'h0);
        chk("post_rst_neg",  32'(bus.neg),  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
